// File: rtl/cache_core_rsp_arbiter_if.sv
// Bank-response / core-response handshake bundle shared by the arbiter and its neighbours.
interface cache_core_rsp_arbiter_if #(
    parameter int NUM_BANKS        = 4,
    parameter int CORE_TAG_ID_BITS = 4
);
    localparam int LW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic [NUM_BANKS-1:0]                  per_bank_rsp_valid;
    logic [NUM_BANKS*CORE_TAG_ID_BITS-1:0] per_bank_rsp_tag_id;
    logic [NUM_BANKS-1:0]                  per_bank_rsp_ready;
    logic                                  sel_valid;
    logic [NUM_BANKS-1:0]                  sel_mask;
    logic [LW-1:0]                         sel_leader;
    logic                                  core_rsp_ready;

    modport slave (
        input  per_bank_rsp_valid, per_bank_rsp_tag_id, core_rsp_ready,
        output per_bank_rsp_ready, sel_valid, sel_mask, sel_leader
    );

    modport master (
        output per_bank_rsp_valid, per_bank_rsp_tag_id, core_rsp_ready,
        input  per_bank_rsp_ready, sel_valid, sel_mask, sel_leader
    );
endinterface

// File: rtl/cache_core_rsp_arbiter.sv
// Round-robin arbiter merging same-tag bank responses onto the single core response port.
// Optional perf counters are built only when CACHE_RSP_ARB_PERF_EN is defined.
module cache_core_rsp_arbiter #(
    parameter int NUM_BANKS        = 4,
    parameter int CORE_TAG_ID_BITS = 4,
    parameter int PRIO_INIT        = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    cache_core_rsp_arbiter_if.slave    bus,
    output logic [31:0]                perf_stall_cycles,
    output logic [31:0]                perf_split_events,
    output logic                       o_dbg_state
);
    localparam int LW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    // Handshake: a bank holds valid/tag until its ready pulses; a grant (sel_valid)
    // fires on core_rsp_ready, and ready to the granted banks is that same pulse.
    typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

    state_t                      r_state, w_state_nx;
    logic [NUM_BANKS-1:0]        r_mask, w_cand, w_mask;
    logic [LW-1:0]               r_leader, w_prio, w_prio_nx, w_ptr, w_lead, w_idx;
    logic [CORE_TAG_ID_BITS-1:0] w_lead_tag;
    logic                        w_found, w_fire, w_load, w_clear;

    assign w_fire    = (r_state == S_GRANT) && bus.core_rsp_ready;
    assign w_prio_nx = LW'((int'(r_leader) + 1) % NUM_BANKS);

    generate
        if (NUM_BANKS == 1) begin : g_single
            assign w_prio = '0;
        end else begin : g_multi
            logic [LW-1:0] r_prio;
            always_ff @(posedge clk) begin
                if (!reset)      r_prio <= LW'(PRIO_INIT);
                else if (w_fire) r_prio <= w_prio_nx;
            end
            assign w_prio = r_prio;
        end
    endgenerate

    // Re-arbitration on fire already uses the rotated pointer and skips the banks just served.
    assign w_ptr  = (r_state == S_GRANT) ? w_prio_nx : w_prio;
    assign w_cand = (r_state == S_GRANT) ? (bus.per_bank_rsp_valid & ~r_mask)
                                         : bus.per_bank_rsp_valid;

    always_comb begin
        w_found    = 1'b0;
        w_lead     = '0;
        w_idx      = '0;
        w_mask     = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            w_idx = LW'((int'(w_ptr) + k) % NUM_BANKS);
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_lead  = w_idx;
            end
        end
        w_lead_tag = bus.per_bank_rsp_tag_id[w_lead*CORE_TAG_ID_BITS +: CORE_TAG_ID_BITS];
        for (int i = 0; i < NUM_BANKS; i++) begin
            w_mask[i] = w_cand[i] &&
                (bus.per_bank_rsp_tag_id[i*CORE_TAG_ID_BITS +: CORE_TAG_ID_BITS] == w_lead_tag);
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_clear    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_load     = 1'b1;
                    w_state_nx = S_GRANT;
                end
            end
            S_GRANT: begin
                if (bus.core_rsp_ready) begin
                    if (w_found) begin
                        w_load = 1'b1;
                    end else begin
                        w_clear    = 1'b1;
                        w_state_nx = S_IDLE;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_mask   <= '0;
            r_leader <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_load) begin
                r_mask   <= w_mask;
                r_leader <= w_lead;
            end else if (w_clear) begin
                r_mask <= '0;
            end
        end
    end

    assign bus.sel_valid          = (r_state == S_GRANT);
    assign bus.sel_mask           = r_mask;
    assign bus.sel_leader         = r_leader;
    assign bus.per_bank_rsp_ready = r_mask & {NUM_BANKS{bus.core_rsp_ready && (r_state == S_GRANT)}};
    assign o_dbg_state            = r_state;

`ifdef CACHE_RSP_ARB_PERF_EN
    logic [31:0] r_stall_cnt, r_split_cnt;
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
            r_split_cnt <= '0;
        end else begin
            if ((r_state == S_GRANT) && !bus.core_rsp_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_load && (|(w_cand & ~w_mask)))              r_split_cnt <= r_split_cnt + 32'd1;
        end
    end
    assign perf_stall_cycles = r_stall_cnt;
    assign perf_split_events = r_split_cnt;
`else
    assign perf_stall_cycles = 32'd0;
    assign perf_split_events = 32'd0;
`endif

    a_granted_hold: assert property (@(posedge clk) disable iff (!reset)
        (r_state == S_GRANT) |-> ((bus.per_bank_rsp_valid & r_mask) == r_mask));

endmodule

// File: doc/cache_core_rsp_arbiter.md
Name: cache_core_rsp_arbiter

Overview:
- Round-robin scheduler that shares the single core response port among the cache banks.
- Each cycle it picks a leader bank and groups every valid bank carrying the same core tag ID into one merged response.
- It holds that grant until the core accepts the response, then rotates priority so that no bank starves.
- It sits between the per-bank response outputs and the core response merge datapath, and drives the per-bank ready signals.

Parameters:
- NUM_BANKS, 4, number of cache banks competing for the response port (1..32).
- CORE_TAG_ID_BITS, 4, width of the tag-ID field compared for grouping (>=1).
- PRIO_INIT, 0, bank index that holds highest priority after reset.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-low reset; 0 = reset.
- per_bank_rsp_valid  input  NUM_BANKS  bank i has a response pending.
- per_bank_rsp_tag_id  input  NUM_BANKS*CORE_TAG_ID_BITS  tag-ID field of bank i's response.
- per_bank_rsp_ready  output  NUM_BANKS  bank i's response is consumed this cycle.
- sel_valid  output  1  a merged response is granted and presented to the core.
- sel_mask  output  NUM_BANKS  banks included in the current grant.
- sel_leader  output  max(1,clog2(NUM_BANKS))  index of the leader bank; the datapath takes the tag from it.
- core_rsp_ready  input  1  core accepts the merged response.
- perf_stall_cycles  output  32  see Optional Feature.
- perf_split_events  output  32  see Optional Feature.

Behaviour:
- Reset (reset==0 at a clk edge):
  - sel_valid=0, sel_mask=0, sel_leader=0, per_bank_rsp_ready=0.
  - prio_ptr=PRIO_INIT, state=IDLE, perf counters=0.
  - Reset mid-grant abandons the grant; banks keep valid and are re-arbitrated after reset releases.
- State IDLE (sel_valid=0):
  - Candidate set C = per_bank_rsp_valid.
  - If C!=0:
    - Leader L = first set bit of C searching upward from prio_ptr, wrapping modulo NUM_BANKS.
    - Mask M = {i : C[i] and tag_id[i]==tag_id[L]}.
    - Register sel_valid=1, sel_mask=M, sel_leader=L, go to GRANT.
  - Grant latency is 1 cycle from valid to sel_valid.
- State GRANT (sel_valid=1):
  - sel_mask and sel_leader are held stable.
  - per_bank_rsp_ready = sel_mask & {NUM_BANKS{core_rsp_ready}}. This is combinational from core_rsp_ready and a registered mask.
  - Fire = core_rsp_ready.
  - On fire:
    - prio_ptr <= (L+1) mod NUM_BANKS.
    - Re-arbitrate in the same cycle over C' = per_bank_rsp_valid & ~sel_mask, using the new prio_ptr value.
    - If C'!=0, load the new grant and stay in GRANT. This gives back-to-back responses at 1 per cycle.
    - Otherwise clear sel_valid/sel_mask and go to IDLE.
  - No fire: hold everything, with no mask widening. A bank that becomes valid with a matching tag waits for the next arbitration.
- Handshake rules:
  - Banks must hold valid and tag_id stable until their ready pulses.
  - A granted bank dropping valid before fire is a protocol violation; a simulation assertion flags it.
  - Non-granted banks may change freely.
- Priority:
  - prio_ptr updates only on fire.
  - A continuously valid bank is served within NUM_BANKS grants.
- NUM_BANKS==1:
  - L always 0, sel_leader width 1 and held 0.
  - prio_ptr is a constant, and the grouping logic is reduced to the single bank.
- All banks valid with distinct tag IDs: each grant has a single-bit mask, serviced in rotating order.
- All banks valid with the same tag ID: one grant with mask all ones.

Optional Feature:
- Macro CACHE_RSP_ARB_PERF_EN.
- When defined:
  - perf_stall_cycles increments on every cycle with sel_valid==1 and core_rsp_ready==0.
  - perf_split_events increments on every arbitration where some candidate bank is excluded from M because its tag ID mismatches.
  - Both counters are 32-bit, wrap at 2^32, and clear on reset.
- When not defined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
1. Reset with valid=4'b1111 asserted -> sel_valid=0 and ready=0 during reset. First cycle after release: sel_valid=1, leader=0 (PRIO_INIT=0), mask includes only banks whose tag matches bank 0.
2. NUM_BANKS=4, valid=4'b1111, tags {3,3,5,3} for banks 0..3, core_rsp_ready=1 -> grant1 leader=0, mask=4'b1011. Next cycle grant2 leader=2, mask=4'b0100. Then IDLE.
3. core_rsp_ready=0 for 5 cycles under grant mask=4'b0010 -> mask and leader are held stable and ready=0. perf_stall_cycles=5 with CACHE_RSP_ARB_PERF_EN defined, 0 without it.
4. Fairness: all 4 banks continuously valid with distinct tags, ready=1 -> leader sequence 0,1,2,3,0 on consecutive cycles.
5. Mid-grant reset: grant to bank 2, then reset asserted for 1 cycle -> outputs return to 0, prio_ptr=0. After release, bank 0 is served first if valid.
6. Split counting: tags {1,2,1,2}, all valid -> perf_split_events increments by 1 for the first arbitration (banks 1 and 3 excluded). The second grant has no exclusions, so the counter stays at 1.
